// File: rtl/aes_axis_ingress_if.sv
// Stream-side and controller-side bundle for aes_axis_ingress.
// Latency: none (wires only).
// Backpressure: carries s_axis_tready back to the stream source; the ingress stalls the stream while the controller is busy.
//
// Signal summary:
//   s_axis_tdata/tvalid/tlast : 32-bit command/data stream into the ingress
//   s_axis_tready             : ingress ready for a stream word
//   aes_cmd                   : latched leading command word of the current packet
//   fifo_data/fifo_w_e/addr   : one-cycle block write into the controller's input RAM
//   blk_cnt                   : full blocks stored for the current packet
//   start_o / done_i          : controller start pulse / completion pulse
//   overflow_o                : sticky, blocks were dropped in the current packet
interface aes_axis_ingress_if #(
   parameter int FIFO_ADDR_WIDTH = 9,
   parameter int FIFO_DATA_WIDTH = 128
);
   logic [31:0]                s_axis_tdata;
   logic                       s_axis_tvalid;
   logic                       s_axis_tready;
   logic                       s_axis_tlast;
   logic [0:31]                aes_cmd;
   logic [0:FIFO_DATA_WIDTH-1] fifo_data;
   logic                       fifo_w_e;
   logic [FIFO_ADDR_WIDTH-1:0] fifo_addr;
   logic [FIFO_ADDR_WIDTH-1:0] blk_cnt;
   logic                       start_o;
   logic                       done_i;
   logic                       overflow_o;

   // Ingress side.
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, done_i,
      output s_axis_tready, aes_cmd, fifo_data, fifo_w_e, fifo_addr,
             blk_cnt, start_o, overflow_o
   );

   // Stream source / controller side.
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, done_i,
      input  s_axis_tready, aes_cmd, fifo_data, fifo_w_e, fifo_addr,
             blk_cnt, start_o, overflow_o
   );
endinterface

// File: rtl/aes_axis_ingress.sv
// Packs an AXI-Stream command packet (cmd word + 4-word blocks) into 128-bit RAM writes, then starts the AES controller.
// Latency: block write registered one cycle after its 4th word; start_o two cycles after the tlast handshake.
// Backpressure: tready drops from the cycle after tlast until the cycle after done_i is sampled in BUSY.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : aes_axis_ingress_if.slave (stream in, RAM write port, controller start/done, status)
//
// Block layout: fifo_data is declared [0:127]; word k of a block lands on
// bits [32k : 32k+31], so the first stream word is the most significant.
module aes_axis_ingress #(
   parameter int FIFO_ADDR_WIDTH = 9,
   parameter int FIFO_DATA_WIDTH = 128   // only 4 x 32 is supported
) (
   input  logic              clk,
   input  logic              reset,
   aes_axis_ingress_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_LAUNCH  = 2'd2,
      ST_BUSY    = 2'd3
   } state_t;

   // Highest storable block count: the RAM holds 2^W - 1 blocks.
   localparam logic [FIFO_ADDR_WIDTH-1:0] BLK_MAX = '1;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       r_tready;
   logic                       w_tready_nxt;
   logic                       r_start;

   logic [0:31]                r_cmd;
   logic [0:95]                r_acc;      // words 0..2 of the block in progress
   logic [1:0]                 r_idx;      // word index inside the block
   logic [0:FIFO_DATA_WIDTH-1] r_data;
   logic                       r_we;
   logic [FIFO_ADDR_WIDTH-1:0] r_addr;
   logic [FIFO_ADDR_WIDTH-1:0] r_blk_cnt;
   logic                       r_ovf;

   logic                       w_acc;
   logic                       w_room;
   logic [6:0]                 w_slot;

   assign w_acc  = bus.s_axis_tvalid & r_tready;
   assign w_room = (r_blk_cnt != BLK_MAX);
   assign w_slot = {r_idx, 5'd0};

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_tready <= 1'b0;
         r_start  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         // tready is registered so it is 0 during reset and only rises on
         // the first edge after release.
         r_tready <= w_tready_nxt;
         // The LAUNCH cycle produces a one-cycle start in the first BUSY cycle.
         r_start  <= (r_state == ST_LAUNCH);
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_acc) begin
               w_state_nxt = bus.s_axis_tlast ? ST_LAUNCH : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (w_acc && bus.s_axis_tlast) begin
               w_state_nxt = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            w_state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            // A done coinciding with our own start pulse belongs to no job
            // of ours, so it is not taken.
            if (bus.done_i && !r_start) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_tready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_COLLECT);
   end

   // ------------------------------------------------------------------
   // Datapath: command latch, block assembly, RAM write port
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd     <= '0;
         r_acc     <= '0;
         r_idx     <= 2'd0;
         r_data    <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_blk_cnt <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_acc && (r_state == ST_IDLE)) begin
            r_cmd     <= bus.s_axis_tdata;
            r_blk_cnt <= '0;
            r_idx     <= 2'd0;
            r_addr    <= '0;
            r_ovf     <= 1'b0;
         end else if (w_acc && (r_state == ST_COLLECT)) begin
            if (r_idx == 2'd3) begin
               r_idx <= 2'd0;
               if (w_room) begin
                  r_we      <= 1'b1;
                  r_addr    <= r_blk_cnt;
                  r_data    <= {r_acc, bus.s_axis_tdata};
                  r_blk_cnt <= r_blk_cnt + 1'b1;
               end else begin
                  // RAM full: the block is dropped and the packet is flagged.
                  r_ovf <= 1'b1;
               end
            end else begin
               r_acc[w_slot +: 32] <= bus.s_axis_tdata;
               r_idx               <= r_idx + 2'd1;
            end
         end
         // A partial block at tlast simply stays in r_acc and is forgotten
         // when the next command word resets the index.
      end
   end

   assign bus.s_axis_tready = r_tready;
   assign bus.aes_cmd       = r_cmd;
   assign bus.fifo_data     = r_data;
   assign bus.fifo_w_e      = r_we;
   assign bus.fifo_addr     = r_addr;
   assign bus.blk_cnt       = r_blk_cnt;
   assign bus.start_o       = r_start;
   assign bus.overflow_o    = r_ovf;

endmodule
